// File: rtl/bu2_window_accum.sv
// Windowed accumulator for a signed sample stream: saturating window sum,
// peak |sample| and a one-cycle result pulse per WIN accepted samples.
module bu2_window_accum #(
  parameter int DATA_W = 8,
  parameter int WIN    = 8,
  parameter int ACC_W  = 12
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  input  logic                     clear,
  output logic signed [ACC_W-1:0]  sum,
  output logic        [DATA_W:0]   peak,
  output logic                     sum_valid,
  output logic                     ovf,
  output logic        [7:0]        count
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [7:0]       LAST    = 8'(WIN - 1);
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [DATA_W:0]    pk_q, pk_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         count_q, count_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic [DATA_W:0]    peak_q, peak_d;
  logic               ovf_out_q, ovf_out_d;
  logic               valid_q, valid_d;

  logic [ACC_W:0]     wide;
  logic               sat_hit;
  logic [ACC_W-1:0]   acc_sat;
  logic [DATA_W:0]    smp_ext;
  logic [DATA_W:0]    smp_abs;
  logic [DATA_W:0]    pk_new;
  logic               ovf_new;

  // One guard bit above the accumulator exposes signed overflow of the add.
  assign wide    = {acc_q[ACC_W-1], acc_q}
                 + {{(ACC_W+1-DATA_W){in_data[DATA_W-1]}}, in_data};
  assign sat_hit = wide[ACC_W] ^ wide[ACC_W-1];
  assign acc_sat = sat_hit ? (wide[ACC_W] ? ACC_MIN : ACC_MAX) : wide[ACC_W-1:0];

  // Magnitude is formed one bit wider so the most negative sample does not wrap.
  assign smp_ext = {in_data[DATA_W-1], in_data};
  assign smp_abs = smp_ext[DATA_W] ? (~smp_ext + {{DATA_W{1'b0}}, 1'b1}) : smp_ext;
  assign pk_new  = (smp_abs > pk_q) ? smp_abs : pk_q;
  assign ovf_new = ovf_q | sat_hit;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_d   = state_q;
    acc_d     = acc_q;
    pk_d      = pk_q;
    ovf_d     = ovf_q;
    count_d   = count_q;
    sum_d     = sum_q;
    peak_d    = peak_q;
    ovf_out_d = ovf_out_q;
    valid_d   = 1'b0;

    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      pk_d    = '0;
      ovf_d   = 1'b0;
      count_d = '0;
    end else if (in_valid) begin
      if (state_q == ACCUM && count_q == LAST) begin
        sum_d     = acc_sat;
        peak_d    = pk_new;
        ovf_out_d = ovf_new;
        valid_d   = 1'b1;
        state_d   = IDLE;
        acc_d     = '0;
        pk_d      = '0;
        ovf_d     = 1'b0;
        count_d   = '0;
      end else begin
        state_d = ACCUM;
        acc_d   = acc_sat;
        pk_d    = pk_new;
        ovf_d   = ovf_new;
        count_d = count_q + 8'd1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      pk_q      <= '0;
      ovf_q     <= 1'b0;
      count_q   <= '0;
      sum_q     <= '0;
      peak_q    <= '0;
      ovf_out_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      pk_q      <= pk_d;
      ovf_q     <= ovf_d;
      count_q   <= count_d;
      sum_q     <= sum_d;
      peak_q    <= peak_d;
      ovf_out_q <= ovf_out_d;
      valid_q   <= valid_d;
    end
  end

  assign sum       = sum_q;
  assign peak      = peak_q;
  assign ovf       = ovf_out_q;
  assign sum_valid = valid_q;
  assign count     = count_q;

endmodule

// File: tb/tb_bu2_window_accum.sv
// Directed bench for bu2_window_accum: a WIN=4 instance with a 12-bit
// accumulator and a WIN=4 instance with an 8-bit accumulator share stimulus.
module tb_bu2_window_accum;

  logic        clock;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        clear;

  logic [11:0] sum_a;
  logic [8:0]  peak_a;
  logic        valid_a;
  logic        ovf_a;
  logic [7:0]  count_a;

  logic [7:0]  sum_b;
  logic [8:0]  peak_b;
  logic        valid_b;
  logic        ovf_b;
  logic [7:0]  count_b;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  bu2_window_accum #(.DATA_W(8), .WIN(4), .ACC_W(12)) u_dut (
    .clock    (clock),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .clear    (clear),
    .sum      (sum_a),
    .peak     (peak_a),
    .sum_valid(valid_a),
    .ovf      (ovf_a),
    .count    (count_a)
  );

  bu2_window_accum #(.DATA_W(8), .WIN(4), .ACC_W(8)) u_sat (
    .clock    (clock),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .clear    (clear),
    .sum      (sum_b),
    .peak     (peak_b),
    .sum_valid(valid_b),
    .ovf      (ovf_b),
    .count    (count_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic step(input logic [7:0] d, input logic v, input logic c);
    @(negedge clock);
    in_data  = d;
    in_valid = v;
    clear    = c;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset    = 1'b0;
    in_data  = '0;
    in_valid = 1'b0;
    clear    = 1'b0;

    // Reset and idle
    repeat (2) @(posedge clock);
    #1;
    check("rst_sum",   32'(sum_a),   32'd0);
    check("rst_peak",  32'(peak_a),  32'd0);
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_ovf",   32'(ovf_a),   32'd0);
    check("rst_count", 32'(count_a), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(8'h00, 1'b0, 1'b0);
      check("idle_valid", 32'(valid_a), 32'd0);
      check("idle_count", 32'(count_a), 32'd0);
      check("idle_sum",   32'(sum_a),   32'd0);
    end

    // Basic window 1,2,3,4
    step(8'd1, 1'b1, 1'b0);
    check("basic_cnt1", 32'(count_a), 32'd1);
    check("basic_v1",   32'(valid_a), 32'd0);
    step(8'd2, 1'b1, 1'b0);
    check("basic_cnt2", 32'(count_a), 32'd2);
    step(8'd3, 1'b1, 1'b0);
    check("basic_cnt3", 32'(count_a), 32'd3);
    check("basic_v3",   32'(valid_a), 32'd0);
    step(8'd4, 1'b1, 1'b0);
    check("basic_cnt0", 32'(count_a), 32'd0);
    check("basic_v4",   32'(valid_a), 32'd1);
    check("basic_sum",  32'(sum_a),   32'd10);
    check("basic_peak", 32'(peak_a),  32'd4);
    check("basic_ovf",  32'(ovf_a),   32'd0);
    step(8'h00, 1'b0, 1'b0);
    check("basic_vdrop", 32'(valid_a), 32'd0);
    check("basic_hold",  32'(sum_a),   32'd10);

    // Signed samples with a gap: -128, 5, gap, 127, -1
    step(8'h80, 1'b1, 1'b0);
    step(8'h05, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(8'h7F, 1'b0, 1'b0);
      check("gap_valid", 32'(valid_a), 32'd0);
      check("gap_count", 32'(count_a), 32'd2);
    end
    step(8'h7F, 1'b1, 1'b0);
    step(8'hFF, 1'b1, 1'b0);
    check("signed_valid", 32'(valid_a), 32'd1);
    check("signed_sum",   32'(sum_a),   32'h003);
    check("signed_peak",  32'(peak_a),  32'd128);
    check("signed_ovf",   32'(ovf_a),   32'd0);
    check("signed_sum8",  32'(sum_b),   32'h03);
    check("signed_ovf8",  32'(ovf_b),   32'd0);

    // Positive saturation: 100, 100, -10, 0
    step(8'd100, 1'b1, 1'b0);
    step(8'd100, 1'b1, 1'b0);
    step(8'hF6,  1'b1, 1'b0);
    step(8'h00,  1'b1, 1'b0);
    check("sat_valid8", 32'(valid_b), 32'd1);
    check("sat_sum8",   32'(sum_b),   32'd117);
    check("sat_ovf8",   32'(ovf_b),   32'd1);
    check("sat_peak8",  32'(peak_b),  32'd100);
    check("sat_sum12",  32'(sum_a),   32'h0BE);
    check("sat_ovf12",  32'(ovf_a),   32'd0);

    // Window after saturation: ovf must not carry over
    repeat (4) step(8'd1, 1'b1, 1'b0);
    check("post_sum8",  32'(sum_b),  32'd4);
    check("post_ovf8",  32'(ovf_b),  32'd0);
    check("post_peak8", 32'(peak_b), 32'd1);

    // Negative saturation: -100, -100, -100, 50
    step(8'h9C, 1'b1, 1'b0);
    step(8'h9C, 1'b1, 1'b0);
    step(8'h9C, 1'b1, 1'b0);
    step(8'd50, 1'b1, 1'b0);
    check("nsat_sum8",  32'(sum_b), 32'hB2);
    check("nsat_ovf8",  32'(ovf_b), 32'd1);
    check("nsat_sum12", 32'(sum_a), 32'hF06);
    check("nsat_ovf12", 32'(ovf_a), 32'd0);

    // Clear has priority over a simultaneous sample
    step(8'd7, 1'b1, 1'b0);
    step(8'd7, 1'b1, 1'b0);
    check("clr_pre_cnt", 32'(count_a), 32'd2);
    step(8'd7, 1'b1, 1'b1);
    check("clr_count", 32'(count_a), 32'd0);
    check("clr_valid", 32'(valid_a), 32'd0);
    check("clr_hold",  32'(sum_a),   32'hF06);
    check("clr_ovf8",  32'(ovf_b),   32'd1);
    step(8'd1, 1'b1, 1'b0);
    check("clr_nopulse", 32'(valid_a), 32'd0);
    check("clr_restart", 32'(count_a), 32'd1);
    repeat (3) step(8'd1, 1'b1, 1'b0);
    check("clr_valid4", 32'(valid_a), 32'd1);
    check("clr_sum",    32'(sum_a),   32'd4);
    check("clr_peak",   32'(peak_a),  32'd1);
    check("clr_ovf8b",  32'(ovf_b),   32'd0);

    // Back-to-back windows of 2s
    for (int i = 0; i < 8; i++) begin
      step(8'd2, 1'b1, 1'b0);
      check("b2b_valid", 32'(valid_a), (i == 3 || i == 7) ? 32'd1 : 32'd0);
      check("b2b_count", 32'(count_a), 32'((i + 1) % 4));
      if (i == 3 || i == 7) check("b2b_sum", 32'(sum_a), 32'd8);
    end

    // Asynchronous reset mid-window, between clock edges
    step(8'd2, 1'b1, 1'b0);
    step(8'd2, 1'b1, 1'b0);
    check("arst_pre_cnt", 32'(count_a), 32'd2);
    #2;
    reset = 1'b0;
    #1;
    check("arst_sum",   32'(sum_a),   32'd0);
    check("arst_peak",  32'(peak_a),  32'd0);
    check("arst_count", 32'(count_a), 32'd0);
    check("arst_ovf8",  32'(ovf_b),   32'd0);
    check("arst_valid", 32'(valid_a), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    step(8'h00, 1'b0, 1'b0);
    check("arst_after", 32'(valid_a), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
